// File: rtl/approx_err_monitor.sv
// Windowed error monitor for an approximate adder: accumulates |exact - APPROX| over
// 2^LOG2_WIN accepted samples and reports sum, max, truncated mean and nonzero-error count.
module approx_err_monitor #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned LOG2_WIN = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [WIDTH-1:0]          IN1,
  input  logic [WIDTH-1:0]          IN2,
  input  logic [WIDTH:0]            APPROX,
  output logic                      RES_VALID,
  input  logic                      RES_READY,
  output logic [WIDTH+LOG2_WIN:0]   SUM_AE,
  output logic [WIDTH:0]            MAX_AE,
  output logic [WIDTH:0]            MAE,
  output logic [LOG2_WIN:0]         ERR_CNT,
  output logic                      BUSY
);

  localparam int unsigned EW = WIDTH + 1;
  localparam int unsigned SW = WIDTH + 1 + LOG2_WIN;
  localparam int unsigned CW = LOG2_WIN + 1;
  localparam logic [CW-1:0] NSamp = CW'(1) << LOG2_WIN;

  typedef enum logic [1:0] {StIdle, StAcc, StDrain, StDone} state_t;

  state_t          r_state;
  state_t          w_state_d;
  logic [CW-1:0]   r_cnt;
  logic            r_drain;
  logic            r_s1_vld;
  logic [EW-1:0]   r_s1_exact;
  logic [EW-1:0]   r_s1_approx;
  logic            r_s2_vld;
  logic [EW-1:0]   r_s2_ae;
  logic [SW-1:0]   r_sum;
  logic [EW-1:0]   r_max;
  logic [CW-1:0]   r_err_cnt;

  logic            w_accept;
  logic            w_start;
  logic [EW-1:0]   w_exact;
  logic [EW-1:0]   w_ae;

  assign IN_READY  = (r_state == StAcc) && (r_cnt < NSamp);
  assign w_accept  = IN_VALID && IN_READY;
  assign w_start   = (r_state == StIdle) && START;
  assign RES_VALID = (r_state == StDone);
  assign BUSY      = (r_state != StIdle);
  assign SUM_AE    = r_sum;
  assign MAX_AE    = r_max;
  assign MAE       = r_sum[SW-1:LOG2_WIN];
  assign ERR_CNT   = r_err_cnt;

  assign w_exact = {1'b0, IN1} + {1'b0, IN2};
  // Subtract the smaller from the larger so the magnitude never wraps.
  assign w_ae = (r_s1_exact >= r_s1_approx) ? (r_s1_exact - r_s1_approx)
                                            : (r_s1_approx - r_s1_exact);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (START) w_state_d = StAcc;
      StAcc:   if (w_accept && (r_cnt == NSamp - CW'(1))) w_state_d = StDrain;
      StDrain: if (r_drain) w_state_d = StDone;
      StDone:  if (RES_READY) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= StIdle;
      r_drain <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_drain <= (r_state == StDrain) && !r_drain;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s1_vld    <= 1'b0;
      r_s1_exact  <= '0;
      r_s1_approx <= '0;
      r_s2_vld    <= 1'b0;
      r_s2_ae     <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_exact  <= w_exact;
        r_s1_approx <= APPROX;
      end
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) r_s2_ae <= w_ae;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt     <= '0;
      r_sum     <= '0;
      r_max     <= '0;
      r_err_cnt <= '0;
    end else if (w_start) begin
      r_cnt     <= '0;
      r_sum     <= '0;
      r_max     <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_accept) r_cnt <= r_cnt + CW'(1);
      if (r_s2_vld) begin
        r_sum <= r_sum + SW'(r_s2_ae);
        if (r_s2_ae > r_max) r_max <= r_s2_ae;
        if (r_s2_ae != '0) r_err_cnt <= r_err_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_approx_err_monitor.sv
// Bench for approx_err_monitor (WIDTH=16, N=4): directed and random windows checked
// against a queue of absolute errors computed with plain integer arithmetic.
module tb_approx_err_monitor;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] IN1;
  logic [15:0] IN2;
  logic [16:0] APPROX;
  logic        RES_VALID;
  logic        RES_READY;
  logic [18:0] SUM_AE;
  logic [16:0] MAX_AE;
  logic [16:0] MAE;
  logic [2:0]  ERR_CNT;
  logic        BUSY;

  int          n_pass = 0;
  int          n_total = 0;
  int          q_err[$];
  logic [63:0] e_sum, e_max, e_mae, e_cnt;

  approx_err_monitor #(.WIDTH(16), .LOG2_WIN(2)) dut (
    .CLK(CLK), .RST(RST), .START(START), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN1(IN1), .IN2(IN2), .APPROX(APPROX), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .SUM_AE(SUM_AE), .MAX_AE(MAX_AE), .MAE(MAE), .ERR_CNT(ERR_CNT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [16:0] ap,
                      input int gap);
    int e;
    repeat (gap) begin
      IN_VALID = 1'b0;
      IN1 = 16'($urandom); IN2 = 16'($urandom); APPROX = 17'($urandom);
      tick();
    end
    IN1 = a; IN2 = b; APPROX = ap; IN_VALID = 1'b1;
    chk("in_ready", IN_READY, 1);
    tick();
    IN_VALID = 1'b0;
    e = int'(a) + int'(b) - int'(ap);
    q_err.push_back(e < 0 ? -e : e);
  endtask

  task automatic send_rand(input int gap);
    int a, b, ex, ap, d;
    a = int'($urandom_range(0, 65535));
    b = int'($urandom_range(0, 65535));
    ex = a + b;
    d = int'($urandom_range(1, 40));
    case ($urandom_range(0, 3))
      0: ap = ex;
      1: ap = ex + d;
      2: ap = (ex >= d) ? ex - d : ex + d;
      default: ap = int'($urandom_range(0, 131071));
    endcase
    if (ap > 131071) ap = ex - d;
    send(16'(a), 16'(b), 17'(ap), gap);
  endtask

  task automatic do_start();
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("start_busy", BUSY, 1);
    chk("start_sum_clr", SUM_AE, 0);
    chk("start_max_clr", MAX_AE, 0);
    chk("start_cnt_clr", ERR_CNT, 0);
  endtask

  task automatic wait_result(input string tag);
    int k;
    k = 0;
    while (RES_VALID !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    // Two edges after the accepting edge = third cycle after the acceptance cycle.
    chk({tag, "_latency"}, k, 2);
  endtask

  task automatic check_results(input string tag);
    int s, m, c;
    s = 0; m = 0; c = 0;
    foreach (q_err[i]) begin
      s += q_err[i];
      if (q_err[i] > m) m = q_err[i];
      if (q_err[i] != 0) c++;
    end
    e_sum = 64'(s); e_max = 64'(m); e_mae = 64'(s / 4); e_cnt = 64'(c);
    chk({tag, "_sum"}, SUM_AE, e_sum);
    chk({tag, "_max"}, MAX_AE, e_max);
    chk({tag, "_mae"}, MAE, e_mae);
    chk({tag, "_errcnt"}, ERR_CNT, e_cnt);
    chk({tag, "_in_ready"}, IN_READY, 0);
    q_err.delete();
  endtask

  task automatic release_res(input string tag);
    RES_READY = 1'b1;
    tick();
    RES_READY = 1'b0;
    chk({tag, "_idle_busy"}, BUSY, 0);
    chk({tag, "_idle_rv"}, RES_VALID, 0);
    chk({tag, "_idle_sum"}, SUM_AE, e_sum);
    chk({tag, "_idle_max"}, MAX_AE, e_max);
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; IN_VALID = 1'b0; RES_READY = 1'b0;
    IN1 = '0; IN2 = '0; APPROX = '0;
    repeat (2) tick();
    chk("rst_sum", SUM_AE, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_rv", RES_VALID, 0);
    chk("rst_in_ready", IN_READY, 0);
    RST = 1'b0;
    IN_VALID = 1'b1;
    repeat (3) tick();
    IN_VALID = 1'b0;
    chk("post_rst_idle_busy", BUSY, 0);
    chk("post_rst_idle_cnt", ERR_CNT, 0);

    // Exact approximations.
    do_start();
    for (int i = 0; i < 4; i++) send(16'(1000 * i + 7), 16'(333 + i), 17'(1000 * i + 340 + i), 0);
    wait_result("exact");
    check_results("exact");
    release_res("exact");

    // Constant +3 error.
    do_start();
    for (int i = 0; i < 4; i++) send(16'(50 + i), 16'(9), 17'(50 + i + 9 + 3), 0);
    wait_result("plus3");
    check_results("plus3");
    release_res("plus3");

    // Mixed sign errors with gaps.
    do_start();
    send(16'd100, 16'd200, 17'd295, 2);
    send(16'd7, 16'd8, 17'd15, 0);
    send(16'd40000, 16'd30000, 17'd70000, 3);
    send(16'd1, 16'd2, 17'd4, 1);
    wait_result("mixed");
    check_results("mixed");
    release_res("mixed");

    // Largest possible error.
    do_start();
    for (int i = 0; i < 4; i++) send(16'hFFFF, 16'hFFFF, 17'd0, i & 1);
    wait_result("maxerr");
    check_results("maxerr");
    chk("maxerr_sum_const", SUM_AE, 524280);
    release_res("maxerr");

    // Results held under backpressure while START and IN_VALID are poked.
    do_start();
    for (int i = 0; i < 4; i++) send_rand(int'($urandom_range(0, 2)));
    wait_result("hold");
    check_results("hold");
    for (int i = 0; i < 10; i++) begin
      START = i[0];
      IN_VALID = 1'b1;
      IN1 = 16'($urandom); IN2 = 16'($urandom); APPROX = 17'($urandom);
      tick();
      chk("hold_rv", RES_VALID, 1);
      chk("hold_in_ready", IN_READY, 0);
      chk("hold_sum", SUM_AE, e_sum);
      chk("hold_max", MAX_AE, e_max);
      chk("hold_mae", MAE, e_mae);
      chk("hold_errcnt", ERR_CNT, e_cnt);
    end
    START = 1'b0;
    IN_VALID = 1'b0;
    release_res("hold");
    IN_VALID = 1'b1;
    repeat (3) tick();
    IN_VALID = 1'b0;
    chk("idle_keep_sum", SUM_AE, e_sum);
    chk("idle_keep_errcnt", ERR_CNT, e_cnt);

    // Asynchronous reset mid-window.
    do_start();
    send(16'd10, 16'd10, 17'd27, 0);
    send(16'd5, 16'd5, 17'd1, 0);
    repeat (3) tick();
    chk("part_sum", SUM_AE, 16);
    chk("part_busy", BUSY, 1);
    #2 RST = 1'b1;
    #1;
    chk("arst_sum", SUM_AE, 0);
    chk("arst_max", MAX_AE, 0);
    chk("arst_mae", MAE, 0);
    chk("arst_errcnt", ERR_CNT, 0);
    chk("arst_in_ready", IN_READY, 0);
    chk("arst_rv", RES_VALID, 0);
    chk("arst_busy", BUSY, 0);
    tick();
    RST = 1'b0;
    q_err.delete();
    repeat (2) tick();
    chk("arst_after_busy", BUSY, 0);
    chk("arst_after_sum", SUM_AE, 0);
    do_start();
    for (int i = 0; i < 4; i++) send(16'(i * 11), 16'(i * 13), 17'(i * 24), 0);
    wait_result("after_rst");
    check_results("after_rst");
    release_res("after_rst");

    // Random windows.
    for (int w = 0; w < 8; w++) begin
      do_start();
      for (int i = 0; i < 4; i++) send_rand(int'($urandom_range(0, 3)));
      wait_result("rand");
      check_results("rand");
      repeat ($urandom_range(0, 3)) tick();
      chk("rand_rv_held", RES_VALID, 1);
      release_res("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
